// File: rtl/prach_pkg.sv
// Shared types for the PRACH header stripper: FSM states and ORAN header field view.
package prach_pkg;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_SYNC = 2'd2
    } state_t;

    // ORAN U-plane header fields carried in the first three header beats
    typedef struct packed {
        logic [15:0] size;
        logic [15:0] pc_id;
        logic [15:0] seq_id;
        logic        data_direction;
        logic [2:0]  payload_version;
        logic [3:0]  filter_index;
        logic [7:0]  frame_id;
        logic [3:0]  subframe_id;
        logic [5:0]  slot_id;
        logic [5:0]  symbol_id;
        logic [11:0] section_id;
        logic        rb;
        logic        sym_inc;
        logic [9:0]  start_prbu;
        logic [7:0]  num_prbu;
        logic [7:0]  ud_comp_hdr;
    } prach_hdr_t;

    // Split the used low bits of header beats 0..2 into named fields
    function automatic prach_hdr_t unpack_hdr(input logic [47:0] b0,
                                              input logic [31:0] b1,
                                              input logic [39:0] b2);
        prach_hdr_t h;
        h.size            = b0[47:32];
        h.pc_id           = b0[31:16];
        h.seq_id          = b0[15:0];
        h.data_direction  = b1[31];
        h.payload_version = b1[30:28];
        h.filter_index    = b1[27:24];
        h.frame_id        = b1[23:16];
        h.subframe_id     = b1[15:12];
        h.slot_id         = b1[11:6];
        h.symbol_id       = b1[5:0];
        h.section_id      = b2[39:28];
        h.rb              = b2[27];
        h.sym_inc         = b2[26];
        h.start_prbu      = b2[25:16];
        h.num_prbu        = b2[15:8];
        h.ud_comp_hdr     = b2[7:0];
        return h;
    endfunction

endpackage

// File: rtl/prach_header_strip_if.sv
// Valid/ready beat stream with start/end-of-packet flags.
interface prach_header_strip_if #(
    parameter int unsigned W = 64
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         sop;
    logic         eop;
    logic         ready;

    modport master (output data, valid, sop, eop, input ready);
    modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/prach_skid_buffer.sv
// Two-entry skid FIFO with a registered ready; output driven straight from storage.
module prach_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] push_data_i,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    output logic [W-1:0] pop_data_o,
    output logic         pop_valid_o,
    input  logic         pop_ready_i,
    output logic         empty_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         ready_q;
    logic         push_c;
    logic         pop_c;

    assign push_c = push_valid_i && ready_q;
    assign pop_c  = (cnt_q != 2'd0) && pop_ready_i;

    // Occupancy after this cycle's push/pop
    always_comb begin
        cnt_d = cnt_q + {1'b0, push_c} - {1'b0, pop_c};
    end

    // Storage, pointers and registered not-full
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            if (push_c) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_c) rd_q <= ~rd_q;
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != 2'd2);
        end
    end

    assign push_ready_o = ready_q;
    assign pop_data_o   = mem_q[rd_q];
    assign pop_valid_o  = (cnt_q != 2'd0);
    assign empty_o      = (cnt_q == 2'd0);

endmodule

// File: rtl/prach_header_strip.sv
// Strips per-packet header beats into a sideband vector and widens IQ samples.
module prach_header_strip
    import prach_pkg::*;
#(
    parameter int unsigned IN_W      = 64,
    parameter int unsigned HDR_BEATS = 3,
    parameter int unsigned SMP_IN_W  = 16,
    parameter int unsigned SMP_OUT_W = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      clk_eth_xran,
    input  logic                      rst_eth_xran,
    input  logic                      cfg_msb_align,
    prach_header_strip_if.slave       in_if,
    prach_header_strip_if.master      out_if,
    output logic [HDR_BEATS*IN_W-1:0] hdr_data,
    output logic                      hdr_valid,
    output logic [CNT_W-1:0]          err_nosop,
    output logic [CNT_W-1:0]          err_trunc,
    output logic [CNT_W-1:0]          err_midsop,
    output logic [31:0]               pkt_cnt
);
    localparam int unsigned NSMP   = IN_W / SMP_IN_W;
    localparam int unsigned OUT_W  = NSMP * SMP_OUT_W;
    localparam int unsigned PAD_W  = SMP_OUT_W - SMP_IN_W;
    localparam int unsigned HB_W   = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam int unsigned SKID_W = OUT_W + 2;
    localparam logic [HB_W-1:0] HDR_LAST = HB_W'(HDR_BEATS - 1);

    state_t                    state_q;
    logic [HB_W-1:0]           hdr_cnt_q;
    logic [HDR_BEATS*IN_W-1:0] shadow_q;
    logic [HDR_BEATS*IN_W-1:0] hdr_data_q;
    logic                      hdr_valid_q;
    logic                      align_q;
    logic                      first_q;
    logic                      live_q;
    logic [CNT_W-1:0]          err_nosop_q;
    logic [CNT_W-1:0]          err_trunc_q;
    logic [CNT_W-1:0]          err_midsop_q;
    logic [31:0]               pkt_cnt_q;

    logic [HB_W-1:0]   hdr_idx_c;
    logic              hdr_last_c;
    logic              in_ready_c;
    logic              in_xfer_c;
    logic              out_eop_xfer_c;
    logic [OUT_W-1:0]  wide_c;
    logic [SMP_IN_W-1:0] smp_c;
    logic              skid_ready;
    logic              skid_empty;
    logic              skid_out_valid;
    logic [SKID_W-1:0] skid_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // A SOP beat in S_SYNC behaves as header beat 0
    assign hdr_idx_c  = (state_q == S_SYNC) ? '0 : hdr_cnt_q;
    assign hdr_last_c = (state_q != S_DATA) && ((state_q == S_HDR) || in_if.sop)
                        && (hdr_idx_c == HDR_LAST);

    // Ready is derived from registered state only; the last header beat waits for an empty output
    assign in_ready_c = live_q && ((state_q == S_DATA) ? skid_ready
                                   : (hdr_last_c ? skid_empty : 1'b1));
    assign in_xfer_c  = in_if.valid && in_ready_c;
    assign out_eop_xfer_c = skid_out_valid && out_if.ready && skid_out[SKID_W-1];

    // Per-sample widening using the mode latched at header acceptance
    always_comb begin
        wide_c = '0;
        smp_c  = '0;
        for (int i = 0; i < NSMP; i++) begin
            smp_c = in_if.data[i*SMP_IN_W +: SMP_IN_W];
            if (align_q) wide_c[i*SMP_OUT_W +: SMP_OUT_W] = {smp_c, PAD_W'(0)};
            else         wide_c[i*SMP_OUT_W +: SMP_OUT_W] = {{PAD_W{smp_c[SMP_IN_W-1]}}, smp_c};
        end
    end

    // Packet FSM, header capture, sideband and error counters
    always_ff @(posedge clk_eth_xran) begin
        if (rst_eth_xran) begin
            state_q      <= S_HDR;
            hdr_cnt_q    <= '0;
            shadow_q     <= '0;
            hdr_data_q   <= '0;
            hdr_valid_q  <= 1'b0;
            align_q      <= 1'b0;
            first_q      <= 1'b0;
            live_q       <= 1'b0;
            err_nosop_q  <= '0;
            err_trunc_q  <= '0;
            err_midsop_q <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            live_q <= 1'b1;
            if (out_eop_xfer_c) hdr_valid_q <= 1'b0;
            if (in_xfer_c) begin
                if (state_q == S_DATA) begin
                    first_q <= 1'b0;
                    if (in_if.sop) err_midsop_q <= sat_inc(err_midsop_q);
                    if (in_if.eop) begin
                        pkt_cnt_q <= pkt_cnt_q + 32'd1;
                        state_q   <= S_HDR;
                    end
                end else if ((state_q == S_SYNC) && !in_if.sop) begin
                    state_q <= S_SYNC;
                end else if ((hdr_idx_c == '0) && !in_if.sop) begin
                    err_nosop_q <= sat_inc(err_nosop_q);
                    state_q     <= S_SYNC;
                end else if (in_if.eop) begin
                    err_trunc_q <= sat_inc(err_trunc_q);
                    hdr_cnt_q   <= '0;
                    state_q     <= S_HDR;
                end else if (hdr_last_c) begin
                    hdr_data_q  <= shadow_q;
                    hdr_data_q[(HDR_BEATS-1)*IN_W +: IN_W] <= in_if.data;
                    hdr_valid_q <= 1'b1;
                    align_q     <= cfg_msb_align;
                    first_q     <= 1'b1;
                    hdr_cnt_q   <= '0;
                    state_q     <= S_DATA;
                end else begin
                    shadow_q[hdr_idx_c*IN_W +: IN_W] <= in_if.data;
                    hdr_cnt_q <= hdr_idx_c + HB_W'(1);
                    state_q   <= S_HDR;
                end
            end
        end
    end

    prach_skid_buffer #(
        .W (SKID_W)
    ) u_skid (
        .clk_i        (clk_eth_xran),
        .rst_i        (rst_eth_xran),
        .push_data_i  ({in_if.eop, first_q, wide_c}),
        .push_valid_i (in_if.valid && (state_q == S_DATA)),
        .push_ready_o (skid_ready),
        .pop_data_o   (skid_out),
        .pop_valid_o  (skid_out_valid),
        .pop_ready_i  (out_if.ready),
        .empty_o      (skid_empty)
    );

    assign in_if.ready = in_ready_c;
    assign out_if.valid = skid_out_valid;
    assign out_if.eop   = skid_out[SKID_W-1];
    assign out_if.sop   = skid_out[SKID_W-2];
    assign out_if.data  = skid_out[OUT_W-1:0];
    assign hdr_data   = hdr_data_q;
    assign hdr_valid  = hdr_valid_q;
    assign err_nosop  = err_nosop_q;
    assign err_trunc  = err_trunc_q;
    assign err_midsop = err_midsop_q;
    assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_prach_header_strip.sv
// Directed bench for prach_header_strip with an output-beat scoreboard.
module tb_prach_header_strip;
    localparam int unsigned IN_W  = 64;
    localparam int unsigned HB    = 3;
    localparam int unsigned OUT_W = 128;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic cfg;
    always #5 clk = ~clk;

    prach_header_strip_if #(.W(IN_W))  in_if ();
    prach_header_strip_if #(.W(OUT_W)) out_if ();

    logic [HB*IN_W-1:0] hdr_data;
    logic               hdr_valid;
    logic [CNT_W-1:0]   err_nosop, err_trunc, err_midsop;
    logic [31:0]        pkt_cnt;

    prach_header_strip #(
        .IN_W(IN_W), .HDR_BEATS(HB), .SMP_IN_W(16), .SMP_OUT_W(32), .CNT_W(CNT_W)
    ) dut (
        .clk_eth_xran (clk),
        .rst_eth_xran (rst),
        .cfg_msb_align(cfg),
        .in_if        (in_if),
        .out_if       (out_if),
        .hdr_data     (hdr_data),
        .hdr_valid    (hdr_valid),
        .err_nosop    (err_nosop),
        .err_trunc    (err_trunc),
        .err_midsop   (err_midsop),
        .pkt_cnt      (pkt_cnt)
    );

    typedef struct packed {
        logic [OUT_W-1:0]   data;
        logic               sop;
        logic               eop;
        logic [HB*IN_W-1:0] hdr;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_fail = 0;
    bit rnd = 1'b0;
    int e_nosop = 0, e_trunc = 0, e_midsop = 0, e_pkt = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference widening: arithmetic sign extension or left shift into the top half
    function automatic logic [OUT_W-1:0] widen(input logic [IN_W-1:0] d, input bit m);
        logic [OUT_W-1:0] r;
        logic [15:0] s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = d[i*16 +: 16];
            if (m) r[i*32 +: 32] = 32'(s) << 16;
            else   r[i*32 +: 32] = 32'($signed(s));
        end
        return r;
    endfunction

    // One clock: optionally randomise out_ready, score any output transfer, advance to next negedge
    task automatic step();
        exp_t e;
        if (rnd) out_if.ready = ($urandom_range(0, 1) == 1);
        #1;
        if (out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
            chk("sb_has_entry", 256'(sb.size() != 0), 256'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_data", out_if.data, e.data);
                chk("out_sop", out_if.sop, e.sop);
                chk("out_eop", out_if.eop, e.eop);
                chk("hdr_data", hdr_data, e.hdr);
                chk("hdr_valid", hdr_valid, 1'b1);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input bit s, input bit e);
        bit acc;
        acc = 1'b0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.sop   = s;
        in_if.eop   = e;
        for (int i = 0; i < 500; i++) begin
            #1;
            acc = (in_if.ready === 1'b1);
            step();
            if (acc) break;
        end
        chk("in_accept", 256'(acc), 256'(1));
    endtask

    task automatic send_pkt(input logic [IN_W-1:0] h0, input logic [IN_W-1:0] h1,
                            input logic [IN_W-1:0] h2, input int nd,
                            input logic [IN_W-1:0] dbase, input bit mode,
                            input bit toggle, input int midsop_at);
        exp_t e;
        logic [IN_W-1:0] d;
        cfg = mode;
        send_beat(h0, 1'b1, 1'b0);
        send_beat(h1, 1'b0, 1'b0);
        send_beat(h2, 1'b0, 1'b0);
        if (toggle) cfg = ~mode;
        for (int j = 0; j < nd; j++) begin
            d      = dbase + 64'(j) * 64'h0011_0022_0033_0044;
            e.data = widen(d, mode);
            e.sop  = (j == 0);
            e.eop  = (j == nd - 1);
            e.hdr  = {h2, h1, h0};
            sb.push_back(e);
            send_beat(d, j == midsop_at, j == nd - 1);
        end
        e_pkt++;
        if (midsop_at > 0 && midsop_at < nd) e_midsop++;
    endtask

    task automatic drain(input string tag);
        rnd = 1'b0;
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && out_if.valid !== 1'b1) break;
            step();
        end
        step();
        chk({tag, "_drained"}, 256'(sb.size()), 256'(0));
        chk({tag, "_out_valid"}, out_if.valid, 1'b0);
        chk({tag, "_hdr_valid_low"}, hdr_valid, 1'b0);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 32'(e_pkt));
        chk({tag, "_err_nosop"}, err_nosop, CNT_W'(e_nosop));
        chk({tag, "_err_trunc"}, err_trunc, CNT_W'(e_trunc));
        chk({tag, "_err_midsop"}, err_midsop, CNT_W'(e_midsop));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, out_if.valid, 1'b0);
        chk({tag, "_out_sop"}, out_if.sop, 1'b0);
        chk({tag, "_out_eop"}, out_if.eop, 1'b0);
        chk({tag, "_out_data"}, out_if.data, '0);
        chk({tag, "_in_ready"}, in_if.ready, 1'b0);
        chk({tag, "_hdr_data"}, hdr_data, '0);
        chk({tag, "_hdr_valid"}, hdr_valid, 1'b0);
        chk({tag, "_errs"}, {err_nosop, err_trunc, err_midsop}, '0);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 32'd0);
    endtask

    initial begin
        logic [IN_W-1:0] h0, h1, h2;
        exp_t e;
        rst = 1'b1;
        cfg = 1'b0;
        in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.data = '0;
        out_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;
        step();

        // 1: sign-extend packet, lane 0 sample 0x8001
        send_pkt(64'h0000_0100_0001_0042, 64'h0000_0000_1234_5678, 64'h0000_00AB_CDEF_0102,
                 4, 64'h7FFF_0001_FFFF_8001, 1'b0, 1'b0, -1);
        drain("t1");

        // 2: MSB-align packet, mode toggled after header
        send_pkt(64'h0000_0200_0002_0043, 64'h0000_0000_8765_4321, 64'h0000_0011_2233_4455,
                 4, 64'h7FFF_0001_FFFF_8001, 1'b1, 1'b1, -1);
        drain("t2");

        // 3: 100 back-to-back packets with random output backpressure
        rnd = 1'b1;
        for (int p = 0; p < 100; p++) begin
            send_pkt({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                     int'($urandom_range(1, 4)), {$urandom, $urandom},
                     bit'($urandom_range(0, 1)), 1'b0, -1);
        end
        drain("t3");

        // 4: header beat 0 without SOP, then junk, then a good packet
        send_beat(64'hDEAD_0000_0000_0001, 1'b0, 1'b0);
        e_nosop++;
        send_beat(64'hDEAD_0000_0000_0002, 1'b0, 1'b0);
        send_beat(64'hDEAD_0000_0000_0003, 1'b0, 1'b1);
        send_pkt(64'h1, 64'h2, 64'h3, 2, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, -1);
        drain("t4");

        // 5: EOP on header beat 1, zero-data packet, good packet, SOP on data beat 2
        send_beat(64'hA0, 1'b1, 1'b0);
        send_beat(64'hA1, 1'b0, 1'b1);
        e_trunc++;
        send_beat(64'hB0, 1'b1, 1'b0);
        send_beat(64'hB1, 1'b0, 1'b0);
        send_beat(64'hB2, 1'b0, 1'b1);
        e_trunc++;
        send_pkt(64'hC0, 64'hC1, 64'hC2, 3, 64'h8000_7FFF_0000_FFFF, 1'b1, 1'b0, -1);
        send_pkt(64'hD0, 64'hD1, 64'hD2, 4, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1);
        drain("t5");

        // 6: reset in the middle of a packet's data
        h0 = 64'hE0; h1 = 64'hE1; h2 = 64'hE2;
        cfg = 1'b0;
        send_beat(h0, 1'b1, 1'b0);
        send_beat(h1, 1'b0, 1'b0);
        send_beat(h2, 1'b0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            e.data = widen(64'(j + 5), 1'b0);
            e.sop  = (j == 0);
            e.eop  = 1'b0;
            e.hdr  = {h2, h1, h0};
            sb.push_back(e);
            send_beat(64'(j + 5), 1'b0, 1'b0);
        end
        rst = 1'b1;
        in_if.valid = 1'b0;
        step();
        chk_reset("rst_mid");
        chk("rst_mid_sb", 256'(sb.size()), 256'(0));
        e_nosop = 0; e_trunc = 0; e_midsop = 0; e_pkt = 0;
        rst = 1'b0;
        step();
        send_beat(64'h7, 1'b0, 1'b0);
        e_nosop++;
        send_beat(64'h8, 1'b0, 1'b1);
        send_pkt(64'hF0, 64'hF1, 64'hF2, 2, 64'hFFFF_8000_7FFF_0001, 1'b1, 1'b0, -1);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
